decode_stage: RTL

Pipelined, parametrised RV32I/RV64I instruction decode stage sitting between the fetch register and the execute stage of the RISC-V core. It accepts one instruction per cycle over a valid/ready handshake and registers a fully decoded bundle for execute:
- register indices
- format-selected, sign-extended immediate
- ALU and datapath control
- illegal flag

Adds flush, backpressure, automatic load-use bubble insertion and optional M-extension decode.

---
 rtl/riscv_pkg.sv | 43 ++++
 rtl/decode_stage_if.sv | 42 ++++
 rtl/decode_comb.sv | 149 ++++++++++++++
 rtl/decode_stage.sv | 88 ++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RISC-V decode definitions: opcodes, ALU codes, operand/writeback
// selector encodings and the decoded bundle carried from decode to execute.
package riscv_pkg;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    localparam logic [5:0] ALU_ADD    = 6'b000000;
    localparam logic [5:0] ALU_PASS_B = 6'b100000;
    localparam logic [1:0] ALU_GRP_INT = 2'b00;
    localparam logic [1:0] ALU_GRP_MUL = 2'b01;
    localparam logic [1:0] ALU_GRP_BR  = 2'b11;

    typedef enum logic [1:0] {OPA_RS1 = 2'd0, OPA_PC = 2'd1, OPA_ZERO = 2'd2} op_a_sel_e;
    typedef enum logic [1:0] {OPB_RS2 = 2'd0, OPB_IMM = 2'd1, OPB_FOUR = 2'd2} op_b_sel_e;
    typedef enum logic [1:0] {WB_ALU = 2'd0, WB_MEM = 2'd1, WB_PC4 = 2'd2} wb_sel_e;

    // Immediate is kept at 32 bits; the stage sign-extends it to XLEN.
    typedef struct packed {
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic [5:0]  alu_ctrl;
        op_a_sel_e   op_a_sel;
        op_b_sel_e   op_b_sel;
        logic        reg_wen;
        logic        mem_wen;
        logic        mem_ren;
        wb_sel_e     wb_sel;
        logic        branch_op;
        logic        jump;
        logic        illegal;
    } decode_bundle_t;

endpackage

// File: rtl/decode_stage_if.sv
// Fetch-side and execute-side handshake plus decoded bundle of the decode stage.
interface decode_stage_if #(
    parameter int XLEN = 32,
    parameter int PC_W = 16
);
    logic            in_valid;
    logic            in_ready;
    logic [PC_W-1:0] in_pc;
    logic [31:0]     in_instr;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic [PC_W-1:0] out_pc;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [XLEN-1:0] imm;
    logic [5:0]      alu_ctrl;
    logic [1:0]      op_a_sel;
    logic [1:0]      op_b_sel;
    logic            reg_wen;
    logic            mem_wen;
    logic            mem_ren;
    logic [1:0]      wb_sel;
    logic            branch_op;
    logic            jump;
    logic            illegal;

    modport master (
        output in_valid, in_pc, in_instr, flush, out_ready,
        input  in_ready, out_valid, out_pc, rs1, rs2, rd, imm, alu_ctrl,
               op_a_sel, op_b_sel, reg_wen, mem_wen, mem_ren, wb_sel,
               branch_op, jump, illegal
    );

    modport slave (
        input  in_valid, in_pc, in_instr, flush, out_ready,
        output in_ready, out_valid, out_pc, rs1, rs2, rd, imm, alu_ctrl,
               op_a_sel, op_b_sel, reg_wen, mem_wen, mem_ren, wb_sel,
               branch_op, jump, illegal
    );
endinterface

// File: rtl/decode_comb.sv
// Purely combinational RV32I/RV64I (+optional M) instruction decoder.
module decode_comb
    import riscv_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int ENABLE_M = 0
) (
    input  logic [31:0]    instr_i,
    output decode_bundle_t bundle_o
);
    localparam bit RV64 = (XLEN == 64);

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic        shift_ok;
    logic        bad_funct;
    logic        bad_opcode;
    decode_bundle_t b;

    assign opcode = instr_i[6:0];
    assign funct3 = instr_i[14:12];
    assign funct7 = instr_i[31:25];

    assign imm_i = {{20{instr_i[31]}}, instr_i[31:20]};
    assign imm_s = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
    assign imm_b = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
    assign imm_u = {instr_i[31:12], 12'b0};
    assign imm_j = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};

    // RV64 shift amounts are 6 bits, so only instr[31:26] must be clean there.
    assign shift_ok = RV64
        ? ((instr_i[31:26] == 6'b000000) || (instr_i[31:26] == 6'b010000 && funct3[2]))
        : ((funct7 == 7'b0000000) || (funct7 == 7'b0100000 && funct3[2]));

    always_comb begin
        b          = '0;
        bad_funct  = 1'b0;
        bad_opcode = 1'b0;
        case (opcode)
            OPC_OP: begin
                b.rs1     = instr_i[19:15];
                b.rs2     = instr_i[24:20];
                b.rd      = instr_i[11:7];
                b.reg_wen = 1'b1;
                if (funct7 == 7'b0000001) begin
                    b.alu_ctrl = {ALU_GRP_MUL, 1'b0, funct3};
                    bad_funct  = (ENABLE_M == 0);
                end else begin
                    b.alu_ctrl = {ALU_GRP_INT, instr_i[30], funct3};
                    bad_funct  = !((funct7 == 7'b0000000) ||
                                   (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101)));
                end
            end
            OPC_OP_IMM: begin
                b.rs1      = instr_i[19:15];
                b.rd       = instr_i[11:7];
                b.imm      = imm_i;
                b.op_b_sel = OPB_IMM;
                b.reg_wen  = 1'b1;
                if (funct3 == 3'b001 || funct3 == 3'b101) begin
                    b.alu_ctrl = {ALU_GRP_INT, instr_i[30], funct3};
                    bad_funct  = !shift_ok;
                end else begin
                    b.alu_ctrl = {ALU_GRP_INT, 1'b0, funct3};
                end
            end
            OPC_LOAD: begin
                b.rs1      = instr_i[19:15];
                b.rd       = instr_i[11:7];
                b.imm      = imm_i;
                b.alu_ctrl = ALU_ADD;
                b.op_b_sel = OPB_IMM;
                b.mem_ren  = 1'b1;
                b.wb_sel   = WB_MEM;
                b.reg_wen  = 1'b1;
                bad_funct  = (funct3 == 3'b111) || (!RV64 && (funct3 == 3'b011 || funct3 == 3'b110));
            end
            OPC_STORE: begin
                b.rs1      = instr_i[19:15];
                b.rs2      = instr_i[24:20];
                b.imm      = imm_s;
                b.alu_ctrl = ALU_ADD;
                b.op_b_sel = OPB_IMM;
                b.mem_wen  = 1'b1;
                bad_funct  = funct3[2] || (!RV64 && funct3 == 3'b011);
            end
            OPC_BRANCH: begin
                b.rs1       = instr_i[19:15];
                b.rs2       = instr_i[24:20];
                b.imm       = imm_b;
                b.alu_ctrl  = {ALU_GRP_BR, 1'b0, funct3};
                b.branch_op = 1'b1;
                bad_funct   = (funct3[2:1] == 2'b01);
            end
            OPC_LUI: begin
                b.rd       = instr_i[11:7];
                b.imm      = imm_u;
                b.alu_ctrl = ALU_PASS_B;
                b.op_a_sel = OPA_ZERO;
                b.op_b_sel = OPB_IMM;
                b.reg_wen  = 1'b1;
            end
            OPC_AUIPC: begin
                b.rd       = instr_i[11:7];
                b.imm      = imm_u;
                b.alu_ctrl = ALU_ADD;
                b.op_a_sel = OPA_PC;
                b.op_b_sel = OPB_IMM;
                b.reg_wen  = 1'b1;
            end
            OPC_JAL: begin
                b.rd       = instr_i[11:7];
                b.imm      = imm_j;
                b.alu_ctrl = ALU_ADD;
                b.op_a_sel = OPA_PC;
                b.op_b_sel = OPB_IMM;
                b.wb_sel   = WB_PC4;
                b.jump     = 1'b1;
                b.reg_wen  = 1'b1;
            end
            OPC_JALR: begin
                b.rs1      = instr_i[19:15];
                b.rd       = instr_i[11:7];
                b.imm      = imm_i;
                b.alu_ctrl = ALU_ADD;
                b.op_b_sel = OPB_IMM;
                b.wb_sel   = WB_PC4;
                b.jump     = 1'b1;
                b.reg_wen  = 1'b1;
                bad_funct  = (funct3 != 3'b000);
            end
            default: bad_opcode = 1'b1;
        endcase

        b.illegal = bad_opcode | bad_funct;
        if (b.illegal) begin
            b.reg_wen   = 1'b0;
            b.mem_wen   = 1'b0;
            b.mem_ren   = 1'b0;
            b.branch_op = 1'b0;
            b.jump      = 1'b0;
        end
    end

    assign bundle_o = b;

endmodule

// File: rtl/decode_stage.sv
// Decode pipeline stage: valid/ready output register around decode_comb with
// load-use bubble insertion and flush.
module decode_stage
    import riscv_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int PC_W     = 16,
    parameter int ENABLE_M = 0
) (
    input logic           clk,
    input logic           reset,
    decode_stage_if.slave bus
);
    decode_bundle_t  dec;
    decode_bundle_t  bundle_q, bundle_d;
    logic            out_valid_q, out_valid_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic            hazard;
    logic            in_ready;
    logic            accept;

    decode_comb #(
        .XLEN     (XLEN),
        .ENABLE_M (ENABLE_M)
    ) u_decode (
        .instr_i  (bus.in_instr),
        .bundle_o (dec)
    );

    // Unused register fields decode to x0, and a load to x0 never stalls,
    // so a plain index compare only fires on real reads.
    assign hazard = out_valid_q && bundle_q.mem_ren && (bundle_q.rd != 5'd0) &&
                    ((dec.rs1 == bundle_q.rd) || (dec.rs2 == bundle_q.rd));

    assign in_ready = (!out_valid_q || bus.out_ready) && !hazard && !bus.flush;
    assign accept   = bus.in_valid && in_ready;

    always_comb begin
        out_valid_d = out_valid_q;
        bundle_d    = bundle_q;
        pc_d        = pc_q;
        if (bus.flush) begin
            out_valid_d = 1'b0;
        end else if (accept) begin
            out_valid_d = 1'b1;
            bundle_d    = dec;
            pc_d        = bus.in_pc;
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            bundle_q    <= '0;
            pc_q        <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            bundle_q    <= bundle_d;
            pc_q        <= pc_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_pc    = pc_q;
    assign bus.rs1       = bundle_q.rs1;
    assign bus.rs2       = bundle_q.rs2;
    assign bus.rd        = bundle_q.rd;
    assign bus.alu_ctrl  = bundle_q.alu_ctrl;
    assign bus.op_a_sel  = bundle_q.op_a_sel;
    assign bus.op_b_sel  = bundle_q.op_b_sel;
    assign bus.reg_wen   = bundle_q.reg_wen;
    assign bus.mem_wen   = bundle_q.mem_wen;
    assign bus.mem_ren   = bundle_q.mem_ren;
    assign bus.wb_sel    = bundle_q.wb_sel;
    assign bus.branch_op = bundle_q.branch_op;
    assign bus.jump      = bundle_q.jump;
    assign bus.illegal   = bundle_q.illegal;

    if (XLEN > 32) begin : g_imm_wide
        assign bus.imm = {{(XLEN-32){bundle_q.imm[31]}}, bundle_q.imm};
    end else begin : g_imm_narrow
        assign bus.imm = bundle_q.imm[XLEN-1:0];
    end

endmodule
